// File: rtl/multicycle_cpu_if.sv
// multicycle_cpu_if
// Instruction handshake and status bus between an instruction source and
// the multicycle_cpu core.
//   instruction  source -> core  instruction word
//   instr_valid  source -> core  instruction present
//   instr_ready  core -> source  core idle, next instruction can be taken
//   done         core -> source  one-cycle retire pulse
//   err          core -> source  qualifies done: reserved ALU function
//   zero_flag    core -> source  last valid R-type result was zero
//   carry_flag   core -> source  ADD carry-out / SUB borrow of last R-type
// master = instruction source, slave = core.
interface multicycle_cpu_if #(
    parameter int INSTR_WIDTH = 20
);
    logic [INSTR_WIDTH-1:0] instruction;
    logic                   instr_valid;
    logic                   instr_ready;
    logic                   done;
    logic                   err;
    logic                   zero_flag;
    logic                   carry_flag;

    modport master (
        output instruction, instr_valid,
        input  instr_ready, done, err, zero_flag, carry_flag
    );

    modport slave (
        input  instruction, instr_valid,
        output instr_ready, done, err, zero_flag, carry_flag
    );
endinterface

// File: rtl/multicycle_cpu.sv
// multicycle_cpu
// Multi-cycle CPU core: takes one instruction at a time over a valid/ready
// handshake and runs it through DECODE/EXEC/MEM/WB. Register file and data
// memory are internal.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   bus   multicycle_cpu_if.slave (instruction, instr_valid, instr_ready,
//         done, err, zero_flag, carry_flag)
// Optional feature macro: SCPU_DBG_EN adds combinational debug read ports
//   dbg_reg_addr/dbg_reg_data and dbg_mem_addr/dbg_mem_data.
//
// state   | meaning
// IDLE    | instr_ready high, waiting for handshake
// DECODE  | latch operands from the register file
// EXEC    | ALU result or memory address computed
// MEM     | LOAD reads memory, STORE writes memory
// WB      | register write and flag update
module multicycle_cpu #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_BITS   = 5,
    parameter int REG_BITS    = 2,
    parameter int INSTR_WIDTH = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    multicycle_cpu_if.slave       bus
`ifdef SCPU_DBG_EN
    ,
    input  logic [REG_BITS-1:0]   dbg_reg_addr,
    output logic [DATA_WIDTH-1:0] dbg_reg_data,
    input  logic [ADDR_BITS-1:0]  dbg_mem_addr,
    output logic [DATA_WIDTH-1:0] dbg_mem_data
`endif
);
    localparam int NREGS = 2 ** REG_BITS;
    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam int SUM_W = DATA_WIDTH + 9;

    localparam logic [1:0] CLS_NOP   = 2'b00;
    localparam logic [1:0] CLS_R     = 2'b01;
    localparam logic [1:0] CLS_LOAD  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB
    } state_t;

    state_t state, next_state;

    logic [INSTR_WIDTH-1:0] instr_q;
    logic [1:0]             cls;
    logic [REG_BITS-1:0]    x1, x2, x3;
    logic [7:0]             imm8;
    logic [3:0]             func;

    logic [DATA_WIDTH-1:0]  regs [NREGS];
    logic [DATA_WIDTH-1:0]  mem  [DEPTH];

    logic [DATA_WIDTH-1:0]  op_a, op_b, op_s, result;
    logic                   carry_res;
    logic [ADDR_BITS-1:0]   addr_q;

    logic                   ready_q, done_q, err_q, zero_q, carry_q;
    logic                   accept;

    logic [DATA_WIDTH:0]    add_ext;
    logic [DATA_WIDTH-1:0]  alu_res;
    logic                   alu_carry;
    logic [SUM_W-1:0]       addr_sum;

    assign cls  = instr_q[INSTR_WIDTH-1 -: 2];
    assign x1   = instr_q[INSTR_WIDTH-3 -: REG_BITS];
    assign x2   = instr_q[INSTR_WIDTH-3-REG_BITS -: REG_BITS];
    assign x3   = instr_q[INSTR_WIDTH-3-2*REG_BITS -: REG_BITS];
    assign imm8 = instr_q[11:4];
    assign func = instr_q[3:0];

    assign accept = bus.instr_valid && ready_q;

    assign bus.instr_ready = ready_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.zero_flag   = zero_q;
    assign bus.carry_flag  = carry_q;

    assign add_ext  = {1'b0, op_a} + {1'b0, op_b};
    // Address is formed wide and then truncated, which gives the mod-depth wrap.
    assign addr_sum = SUM_W'(op_a) + SUM_W'(imm8);

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (func)
            4'd0: begin
                alu_res   = add_ext[DATA_WIDTH-1:0];
                alu_carry = add_ext[DATA_WIDTH];
            end
            4'd1: begin
                alu_res   = op_a - op_b;
                alu_carry = (op_a < op_b);
            end
            4'd2: alu_res = op_a & op_b;
            4'd3: alu_res = op_a | op_b;
            4'd4: alu_res = op_a ^ op_b;
            4'd5: alu_res = {op_a[DATA_WIDTH-2:0], 1'b0};
            4'd6: alu_res = {1'b0, op_a[DATA_WIDTH-1:1]};
            4'd7: alu_res = {{(DATA_WIDTH-1){1'b0}}, (op_a < op_b)};
            default: ;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (accept) next_state = S_DECODE;
            S_DECODE: next_state = (cls == CLS_NOP) ? S_IDLE : S_EXEC;
            S_EXEC:   next_state = (cls == CLS_R) ? S_WB : S_MEM;
            S_MEM:    next_state = (cls == CLS_LOAD) ? S_WB : S_IDLE;
            S_WB:     next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= next_state;
            ready_q <= (next_state == S_IDLE);
            // Retire is the return to IDLE from any busy state.
            done_q  <= (state != S_IDLE) && (next_state == S_IDLE);
            err_q   <= (state == S_WB) && (cls == CLS_R) && func[3];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_q   <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_s      <= '0;
            result    <= '0;
            carry_res <= 1'b0;
            addr_q    <= '0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs[i] <= DATA_WIDTH'(i);
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            case (state)
                S_IDLE: if (accept) instr_q <= bus.instruction;
                S_DECODE: begin
                    op_a <= regs[x2];
                    op_b <= regs[x3];
                    op_s <= regs[x1];
                end
                S_EXEC: begin
                    result    <= alu_res;
                    carry_res <= alu_carry;
                    addr_q    <= addr_sum[ADDR_BITS-1:0];
                end
                S_MEM: begin
                    if (cls == CLS_LOAD) result <= mem[addr_q];
                    else                 mem[addr_q] <= op_s;
                end
                S_WB: begin
                    if (cls == CLS_R) begin
                        // Reserved functions leave registers and flags alone.
                        if (!func[3]) begin
                            regs[x1] <= result;
                            zero_q   <= (result == '0);
                            carry_q  <= carry_res;
                        end
                    end else begin
                        regs[x1] <= result;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SCPU_DBG_EN
    assign dbg_reg_data = regs[dbg_reg_addr];
    assign dbg_mem_data = mem[dbg_mem_addr];
`endif

endmodule

// File: tb/tb_multicycle_cpu.sv
module tb_multicycle_cpu;
    logic clk = 1'b0;
    logic rst = 1'b0;

    multicycle_cpu_if #(.INSTR_WIDTH(20)) bus ();

`ifdef SCPU_DBG_EN
    logic [1:0] dbg_reg_addr = '0;
    logic [7:0] dbg_reg_data;
    logic [4:0] dbg_mem_addr = '0;
    logic [7:0] dbg_mem_data;
`endif

    multicycle_cpu #(
        .DATA_WIDTH(8), .ADDR_BITS(5), .REG_BITS(2), .INSTR_WIDTH(20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef SCPU_DBG_EN
        ,
        .dbg_reg_addr(dbg_reg_addr),
        .dbg_reg_data(dbg_reg_data),
        .dbg_mem_addr(dbg_mem_addr),
        .dbg_mem_data(dbg_mem_data)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    int m_reg [4];
    int m_mem [32];
    bit m_zero, m_carry;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [19:0] mk(input int cls, input int x1, input int x2,
                                       input int x3, input int imm, input int fn);
        logic [19:0] w;
        w = {cls[1:0], x1[1:0], x2[1:0], x3[1:0], imm[7:0], fn[3:0]};
        return w;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = i;
        for (int i = 0; i < 32; i++) m_mem[i] = 0;
        m_zero  = 0;
        m_carry = 0;
    endtask

    // Architectural effect of one instruction, plus its expected latency in edges.
    task automatic model_exec(input logic [19:0] ins, output int lat, output bit err,
                              output int maddr);
        int cls, x1, x2, x3, imm, fn, a, b, r;
        bit c;
        cls = int'(ins[19:18]); x1 = int'(ins[17:16]); x2 = int'(ins[15:14]);
        x3 = int'(ins[13:12]); imm = int'(ins[11:4]); fn = int'(ins[3:0]);
        err = 0; maddr = -1; lat = 2;
        a = m_reg[x2]; b = m_reg[x3];
        case (cls)
            0: lat = 2;
            1: begin
                lat = 4;
                if (fn >= 8) err = 1;
                else begin
                    c = 0;
                    case (fn)
                        0: begin r = (a + b) % 256; c = (a + b) > 255; end
                        1: begin r = (a - b + 256) % 256; c = a < b; end
                        2: r = a & b;
                        3: r = a | b;
                        4: r = a ^ b;
                        5: r = (a * 2) % 256;
                        6: r = a / 2;
                        default: r = (a < b) ? 1 : 0;
                    endcase
                    m_reg[x1] = r;
                    m_zero    = (r == 0);
                    m_carry   = c;
                end
            end
            2: begin
                lat = 5;
                maddr = (a + imm) % 32;
                m_reg[x1] = m_mem[maddr];
            end
            default: begin
                lat = 4;
                maddr = (a + imm) % 32;
                m_mem[maddr] = m_reg[x1];
            end
        endcase
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 4; i++) chk($sformatf("%s_r%0d", tag, i), 32'(dut.regs[i]), m_reg[i]);
    endtask

    // Called #1 after a posedge. Optionally keeps instr_valid high with another
    // word during the busy period, which must not be taken until ready returns.
    task automatic run(input logic [19:0] ins, input bit keep_valid, input logic [19:0] nxt);
        int lat, maddr, n;
        bit err, busy_ready;
        for (int k = 0; k < 20 && !bus.instr_ready; k++) begin
            @(posedge clk); #1;
        end
        chk("ready_wait", bus.instr_ready, 1);
        bus.instruction = ins;
        bus.instr_valid = 1'b1;
        model_exec(ins, lat, err, maddr);
        @(posedge clk); #1;
        chk("ready_drop", bus.instr_ready, 0);
        chk("done_pulse", bus.done, 0);
        if (keep_valid) bus.instruction = nxt;
        else begin
            bus.instr_valid = 1'b0;
            bus.instruction = 20'($urandom);
        end
        n = 1;
        busy_ready = 0;
        while (!bus.done && n < 20) begin
            if (bus.instr_ready) busy_ready = 1;
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, lat);
        chk("busy_ready", busy_ready, 0);
        chk("ready_at_done", bus.instr_ready, 1);
        chk("err", bus.err, err);
        chk("zero", bus.zero_flag, m_zero);
        chk("carry", bus.carry_flag, m_carry);
        check_regs("reg");
        if (maddr >= 0) chk("mem", 32'(dut.mem[maddr]), m_mem[maddr]);
    endtask

    task automatic do_reset();
        bus.instr_valid = 1'b0;
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic random_instr(output logic [19:0] w);
        int fn;
        fn = ($urandom_range(0, 7) == 0) ? $urandom_range(8, 15) : $urandom_range(0, 7);
        w = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 255), fn);
    endtask

    initial begin
        logic [19:0] w;
        int addr;
        bus.instruction = '0;
        bus.instr_valid = 1'b0;

        do_reset();
        chk("rst_ready", bus.instr_ready, 1);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_zero", bus.zero_flag, 0);
        chk("rst_carry", bus.carry_flag, 0);
        check_regs("rst");

        run(20'b01000111000000000000, 0, '0);   // ADD r0=r1+r3
        run(mk(1, 1, 0, 3, 0, 0), 0, '0);      // ADD r1=r0+r3
        run(mk(1, 3, 0, 2, 0, 1), 0, '0);      // SUB r3=r0-r2
        run(20'b11011000000011110000, 0, '0);   // STORE mem[r2+15]=r1
        run(20'b10111000000011110000, 0, '0);   // LOAD r3=mem[r2+15]
        run(mk(0, 1, 2, 3, 99, 5), 0, '0);     // NOP

        do_reset();
        run(mk(1, 0, 0, 1, 0, 1), 0, '0);      // SUB r0=r0-r1 -> 255, borrow
        run(mk(3, 2, 0, 0, 15, 0), 0, '0);     // STORE wraps to mem[14]
        run(mk(1, 1, 2, 3, 0, 9), 0, '0);      // reserved func
        run(mk(1, 2, 3, 1, 0, 0), 1, mk(1, 0, 0, 0, 0, 4));
        run(mk(1, 0, 0, 0, 0, 4), 0, '0);      // XOR r0=r0^r0, taken back-to-back

        for (int i = 0; i < 120; i++) begin
            random_instr(w);
            run(w, 0, '0);
        end

        // Reset during a STORE's EXEC state must drop the write.
        for (int k = 0; k < 20 && !bus.instr_ready; k++) begin
            @(posedge clk); #1;
        end
        addr = (m_reg[3] + 4) % 32;
        bus.instruction = mk(3, 2, 3, 0, 4, 0);
        bus.instr_valid = 1'b1;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        #1;
        chk("abort_ready", bus.instr_ready, 1);
        chk("abort_done", bus.done, 0);
        chk("abort_mem", 32'(dut.mem[addr]), 0);
        check_regs("abort");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 80; i++) begin
            random_instr(w);
            run(w, 0, '0);
        end
        for (int i = 0; i < 32; i++) chk($sformatf("mem_final_%0d", i), 32'(dut.mem[i]), m_mem[i]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule
